// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if
//   Bundles every fifo_ctrl signal except clk/rst.
//   Producer/consumer side : flush, wr_en, wr_data, rd_en -> ; <- rd_data, rd_valid,
//                            full, almost_full, empty, almost_empty, count,
//                            ovf_err, udf_err
//   RAM side               : <- ram_we, ram_waddr, ram_wdata, ram_raddr ; -> ram_rdata
//   modport master : the environment (user logic plus the RAM).
//   modport slave  : the FIFO controller.
//
// Handshake: a write is taken in any cycle where wr_en=1 and full=0, and a
// read in any cycle where rd_en=1 and empty=0. full and empty act as the
// inverse ready signals for each direction. Read data comes back exactly one
// cycle later and is qualified by rd_valid.
interface fifo_ctrl_if;
    logic        flush;
    logic        wr_en;
    logic [35:0] wr_data;
    logic        rd_en;
    logic [35:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        almost_full;
    logic        empty;
    logic        almost_empty;
    logic [9:0]  count;
    logic        ovf_err;
    logic        udf_err;
    logic        ram_we;
    logic [8:0]  ram_waddr;
    logic [35:0] ram_wdata;
    logic [8:0]  ram_raddr;
    logic [35:0] ram_rdata;

    modport master (
        output flush, wr_en, wr_data, rd_en, ram_rdata,
        input  rd_data, rd_valid, full, almost_full, empty, almost_empty,
               count, ovf_err, udf_err, ram_we, ram_waddr, ram_wdata, ram_raddr
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, ram_rdata,
        output rd_data, rd_valid, full, almost_full, empty, almost_empty,
               count, ovf_err, udf_err, ram_we, ram_waddr, ram_wdata, ram_raddr
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
//   Pointer/count controller for a 512 x 36 FIFO built around an external
//   simple dual-port RAM (port A write, port B registered read).
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - fifo_ctrl_if.slave, user handshake, status flags and RAM ports
//   Parameters:
//     AFULL_LEVEL  - almost_full when count >= AFULL_LEVEL  (1..512)
//     AEMPTY_LEVEL - almost_empty when count <= AEMPTY_LEVEL (0..511)
module fifo_ctrl #(
    parameter int AFULL_LEVEL  = 496,
    parameter int AEMPTY_LEVEL = 16
) (
    input  logic       clk,
    input  logic       rst,
    fifo_ctrl_if.slave bus
);

    localparam logic [9:0] DEPTH    = 10'd512;
    localparam logic [9:0] AFULL_L  = 10'(AFULL_LEVEL);
    localparam logic [9:0] AEMPTY_L = 10'(AEMPTY_LEVEL);

    logic [8:0] wptr_q, wptr_d;
    logic [8:0] rptr_q, rptr_d;
    logic [9:0] count_q, count_d;
    logic       rd_valid_q, rd_valid_d;
    logic       ovf_err_q, ovf_err_d;
    logic       udf_err_q, udf_err_d;

    logic full, empty;
    logic wr_acc, rd_acc;

    always_comb begin
        // Flags come only from the registered count.
        full  = (count_q == DEPTH);
        empty = (count_q == 10'd0);

        // Reading only when non-empty and writing only when non-full means
        // the read and write addresses can never collide while ram_we=1.
        // flush and rst both suppress any RAM write in their cycle.
        wr_acc = bus.wr_en & ~full  & ~bus.flush & ~rst;
        rd_acc = bus.rd_en & ~empty & ~bus.flush & ~rst;

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_valid_d = rd_acc;

        if (bus.flush) begin
            wptr_d  = 9'd0;
            rptr_d  = 9'd0;
            count_d = 10'd0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 9'd1;
            if (rd_acc) rptr_d = rptr_q + 9'd1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 10'd1;
                2'b01:   count_d = count_q - 10'd1;
                default: count_d = count_q;
            endcase
        end

        // Sticky errors record any request made against the wrong flag,
        // independent of flush; only rst clears them.
        ovf_err_d = ovf_err_q | (bus.wr_en & full);
        udf_err_d = udf_err_q | (bus.rd_en & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= 9'd0;
            rptr_q     <= 9'd0;
            count_q    <= 10'd0;
            rd_valid_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            udf_err_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            ovf_err_q  <= ovf_err_d;
            udf_err_q  <= udf_err_d;
        end
    end

    assign bus.ram_we       = wr_acc;
    assign bus.ram_waddr    = wptr_q;
    assign bus.ram_wdata    = bus.wr_data;
    assign bus.ram_raddr    = rptr_q;
    // The RAM output register supplies the one-cycle read latency.
    assign bus.rd_data      = bus.ram_rdata;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AFULL_L);
    assign bus.almost_empty = (count_q <= AEMPTY_L);
    assign bus.count        = count_q;
    assign bus.ovf_err      = ovf_err_q;
    assign bus.udf_err      = udf_err_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ctrl_if bus();

    fifo_ctrl #(.AFULL_LEVEL(496), .AEMPTY_LEVEL(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: port A write, port B registered read, always enabled.
    logic [35:0] mem [512];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_raddr];
    end

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [35:0] exp_q[$];

    // Reference model of the FIFO occupancy and pointers.
    int   mdl_cnt = 0;
    int   mdl_wp  = 0;
    int   mdl_rp  = 0;
    logic exp_rv  = 1'b0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs for one cycle at the falling edge, check outputs 1 time
    // unit later (registered outputs reflect the previous rising edge), then
    // advance the model across the next rising edge.
    task automatic step(input logic w, input logic [35:0] d, input logic r, input logic f);
        logic wa, ra;
        @(negedge clk);
        rst         = 1'b0;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.flush   = f;
        #1;
        check("rd_valid", {35'd0, bus.rd_valid}, {35'd0, exp_rv});
        if (exp_rv && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rd_q: got data 0x%0h expected none queued", bus.rd_data);
            end else begin
                check("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
        check("count", {26'd0, bus.count}, 36'(mdl_cnt));
        check("ram_raddr", {27'd0, bus.ram_raddr}, 36'(mdl_rp));
        wa = w && (mdl_cnt != 512) && !f;
        ra = r && (mdl_cnt != 0) && !f;
        check("ram_we", {35'd0, bus.ram_we}, {35'd0, wa});
        if (wa) begin
            check("ram_waddr", {27'd0, bus.ram_waddr}, 36'(mdl_wp));
            check("ram_wdata", bus.ram_wdata, d);
        end
        if (f) begin
            mdl_cnt = 0;
            mdl_wp  = 0;
            mdl_rp  = 0;
            exp_q.delete();
        end else begin
            if (wa) begin
                exp_q.push_back(d);
                mdl_wp = (mdl_wp + 1) % 512;
            end
            if (ra) mdl_rp = (mdl_rp + 1) % 512;
            mdl_cnt = mdl_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        end
        exp_rv = ra;
    endtask

    // Reset for one cycle, optionally while a write is being requested.
    task automatic do_reset(input logic w);
        @(negedge clk);
        rst         = 1'b1;
        bus.wr_en   = w;
        bus.wr_data = 36'h0_5555_5555;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        #1;
        check("rst_ram_we", {35'd0, bus.ram_we}, 36'd0);
        mdl_cnt = 0;
        mdl_wp  = 0;
        mdl_rp  = 0;
        exp_rv  = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag, input logic f, input logic af,
                               input logic e, input logic ae);
        check({tag, "_full"},         {35'd0, bus.full},         {35'd0, f});
        check({tag, "_almost_full"},  {35'd0, bus.almost_full},  {35'd0, af});
        check({tag, "_empty"},        {35'd0, bus.empty},        {35'd0, e});
        check({tag, "_almost_empty"}, {35'd0, bus.almost_empty}, {35'd0, ae});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 36'd0;
        bus.rd_en   = 1'b0;

        // Reset state
        do_reset(1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check_flags("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_count", {26'd0, bus.count}, 36'd0);
        check("reset_rd_valid", {35'd0, bus.rd_valid}, 36'd0);
        check("reset_ram_we", {35'd0, bus.ram_we}, 36'd0);
        check("reset_ram_raddr", {27'd0, bus.ram_raddr}, 36'd0);
        check("reset_ovf", {35'd0, bus.ovf_err}, 36'd0);
        check("reset_udf", {35'd0, bus.udf_err}, 36'd0);

        // Three writes then three reads
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 36'(i), 1'b0, 1'b0);
            check("w3_waddr", {27'd0, bus.ram_waddr}, 36'(i - 1));
        end
        step(1'b0, 36'd0, 1'b1, 1'b0);
        check("w3_count3", {26'd0, bus.count}, 36'd3);
        step(1'b0, 36'd0, 1'b1, 1'b0);
        check("r3_data1", bus.rd_data, 36'd1);
        step(1'b0, 36'd0, 1'b1, 1'b0);
        check("r3_data2", bus.rd_data, 36'd2);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("r3_data3", bus.rd_data, 36'd3);
        check("r3_count0", {26'd0, bus.count}, 36'd0);
        check("r3_empty", {35'd0, bus.empty}, 36'd1);

        // Fill to 512, watch the threshold crossings
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 36'h1_0000_0000 + 36'(i), 1'b0, 1'b0);
            if (i == 16)  check("ae_at16",  {35'd0, bus.almost_empty}, 36'd1);
            if (i == 17)  check("ae_at17",  {35'd0, bus.almost_empty}, 36'd0);
            if (i == 495) check("af_at495", {35'd0, bus.almost_full},  36'd0);
            if (i == 496) check("af_at496", {35'd0, bus.almost_full},  36'd1);
            if (i == 511) check("full_at511", {35'd0, bus.full},       36'd0);
        end
        step(1'b1, 36'h0_DEAD_BEEF, 1'b0, 1'b0);
        check("ovf_ram_we", {35'd0, bus.ram_we}, 36'd0);
        check_flags("full512", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("ovf_set", {35'd0, bus.ovf_err}, 36'd1);
        check("ovf_count", {26'd0, bus.count}, 36'd512);

        // Simultaneous read+write when full: only the read is taken
        step(1'b1, 36'h0_BAD0_0001, 1'b1, 1'b0);
        check("full_rw_ram_we", {35'd0, bus.ram_we}, 36'd0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("full_rw_count", {26'd0, bus.count}, 36'd511);
        check("full_rw_data", bus.rd_data, 36'h1_0000_0000);
        while (mdl_cnt > 0) step(1'b0, 36'd0, 1'b1, 1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        // Simultaneous read+write when empty: only the write is taken
        step(1'b1, 36'h0_0000_0777, 1'b1, 1'b0);
        check("empty_rw_ram_we", {35'd0, bus.ram_we}, 36'd1);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("empty_rw_count", {26'd0, bus.count}, 36'd1);
        check("empty_rw_rd_valid", {35'd0, bus.rd_valid}, 36'd0);
        check("empty_rw_udf", {35'd0, bus.udf_err}, 36'd1);

        // Wrap: 600 write/read pairs at a steady count of 5
        do_reset(1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("rst_ovf_clr", {35'd0, bus.ovf_err}, 36'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 36'h2_0000_0000 + 36'(i), 1'b0, 1'b0);
        for (int i = 5; i < 605; i++) step(1'b1, 36'h2_0000_0000 + 36'(i), 1'b1, 1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("wrap_count", {26'd0, bus.count}, 36'd5);
        check("wrap_raddr", {27'd0, bus.ram_raddr}, 36'd88);
        check("wrap_last_data", bus.rd_data, 36'h2_0000_0000 + 36'd599);

        // Underflow, flush keeps the error, reset clears it
        for (int i = 0; i < 5; i++) step(1'b0, 36'd0, 1'b1, 1'b0);
        step(1'b0, 36'd0, 1'b1, 1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("udf_set", {35'd0, bus.udf_err}, 36'd1);
        check("udf_rd_valid", {35'd0, bus.rd_valid}, 36'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 36'h3_0000_0000 + 36'(i), 1'b0, 1'b0);
        step(1'b1, 36'h3_FFFF_FFFF, 1'b1, 1'b1);
        check("flush_count10", {26'd0, bus.count}, 36'd10);
        check("flush_ram_we", {35'd0, bus.ram_we}, 36'd0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("flush_count", {26'd0, bus.count}, 36'd0);
        check("flush_empty", {35'd0, bus.empty}, 36'd1);
        check("flush_udf_kept", {35'd0, bus.udf_err}, 36'd1);
        check("flush_rd_valid", {35'd0, bus.rd_valid}, 36'd0);
        do_reset(1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("rst_udf_clr", {35'd0, bus.udf_err}, 36'd0);

        // Reset during a write burst at count 7
        for (int i = 0; i < 7; i++) step(1'b1, 36'h4_0000_0000 + 36'(i), 1'b0, 1'b0);
        do_reset(1'b1);
        step(1'b1, 36'h0_0000_0ABC, 1'b0, 1'b0);
        check("burst_rst_count", {26'd0, bus.count}, 36'd0);
        check("burst_rst_waddr", {27'd0, bus.ram_waddr}, 36'd0);
        step(1'b0, 36'd0, 1'b1, 1'b0);
        step(1'b0, 36'd0, 1'b0, 1'b0);
        check("burst_rst_data", bus.rd_data, 36'h0_0000_0ABC);
        step(1'b0, 36'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
